// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Command and result streams between a host and the ALU sequencer.
//   cmd_valid/cmd_ready : command handshake, host -> sequencer
//   cmd_op/cmd_a/cmd_b  : opcode and operands carried with a command
//   res_valid/res_ready : result handshake, sequencer -> host
//   res_data/res_err    : captured ALU result and unsupported-opcode flag
// master = host side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface alu_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Buffers ALU commands in a small FIFO, issues them to the ALU one at a
// time, waits ALU_LAT edges after the ALU samples its inputs, captures the
// ALU result and presents it on the result stream until it is taken.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : command stream in, result stream out
//   alu_opcode/num_1/num_2 : registered drive of the ALU inputs
//   alu_ans         : registered ALU result
//   busy            : FSM not idle or commands queued
//   op_count        : number of completed result handshakes (wraps)
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_sequencer_if.slave       bus,
    output logic [3:0]           alu_opcode,
    output logic [7:0]           alu_num_1,
    output logic [7:0]           alu_num_2,
    input  logic [7:0]           alu_ans,
    output logic                 busy,
    output logic [7:0]           op_count
);

    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int CNTW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    // ---------------- command FIFO ----------------
    logic [19:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q;
    logic          empty;
    logic          push, pop;
    logic [19:0]   head;

    assign empty         = (count_q == '0);
    assign bus.cmd_ready = !full_q;
    assign push          = bus.cmd_valid && !full_q;
    assign head          = mem_q[rd_ptr_q];
    assign count_d       = count_q + CW'(push) - CW'(pop);

    // Storage is not reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CW'(FIFO_DEPTH));
        end
    end

    // ---------------- sequencing FSM ----------------
    state_t          state_q, state_d;
    logic [3:0]      opcode_q, opcode_d;
    logic [7:0]      num1_q, num1_d;
    logic [7:0]      num2_q, num2_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_pend_q, err_pend_d;
    logic            res_valid_q, res_valid_d;
    logic [7:0]      res_data_q, res_data_d;
    logic            res_err_q, res_err_d;
    logic [7:0]      op_count_q, op_count_d;
    logic            head_ok;

    assign head_ok = (head[19:16] == 4'h1) || (head[19:16] == 4'h2) ||
                     (head[19:16] == 4'h4) || (head[19:16] == 4'h8);

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        cnt_d       = cnt_q;
        err_pend_d  = err_pend_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        op_count_d  = op_count_q;
        pop         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    opcode_d   = head[19:16];
                    num1_d     = head[15:8];
                    num2_d     = head[7:0];
                    err_pend_d = !head_ok;
                    cnt_d      = CNTW'(ALU_LAT);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // The ALU samples on the edge after issue; counting down
                // from ALU_LAT puts the capture ALU_LAT edges after that.
                if (cnt_q == '0) begin
                    res_data_d  = alu_ans;
                    res_err_d   = err_pend_q;
                    res_valid_d = 1'b1;
                    opcode_d    = 4'h0;
                    state_d     = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'h01;
                    if (!empty) begin
                        // Next issue shares the handshake edge.
                        pop        = 1'b1;
                        opcode_d   = head[19:16];
                        num1_d     = head[15:8];
                        num2_d     = head[7:0];
                        err_pend_d = !head_ok;
                        cnt_d      = CNTW'(ALU_LAT);
                        state_d    = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            opcode_q    <= 4'h0;
            num1_q      <= 8'h00;
            num2_q      <= 8'h00;
            cnt_q       <= '0;
            err_pend_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            res_err_q   <= 1'b0;
            op_count_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            cnt_q       <= cnt_d;
            err_pend_q  <= err_pend_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_opcode    = opcode_q;
    assign alu_num_1     = num1_q;
    assign alu_num_2     = num2_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign op_count      = op_count_q;
    assign busy          = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] alu_opcode;
    logic [7:0] alu_num_1, alu_num_2;
    logic [7:0] alu_ans = 8'h00;
    logic       busy;
    logic [7:0] op_count;

    int passed = 0;
    int total  = 0;

    alu_sequencer_if bus();

    alu_sequencer #(.FIFO_DEPTH(4), .ALU_LAT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_opcode (alu_opcode),
        .alu_num_1  (alu_num_1),
        .alu_num_2  (alu_num_2),
        .alu_ans    (alu_ans),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    // Behavioural registered ALU.
    function automatic logic [7:0] alu_f(logic [3:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            4'h1:    return a + b;
            4'h2:    return a - b;
            4'h4:    return {4'h0, a[3:0]} * {4'h0, b[3:0]};
            4'h8:    return a % 8'd3;
            default: return 8'hFF;
        endcase
    endfunction

    always @(posedge clk) alu_ans <= alu_f(alu_opcode, alu_num_1, alu_num_2);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    // with cmd_valid still asserted.
    task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bit ok = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        for (int i = 0; i < 100; i++) begin
            if (bus.cmd_ready) begin
                @(posedge clk);
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("push_timeout", 0, 1);
        $display("cmd  op=%0h a=%02h b=%02h accepted=%0d", op, a, b, ok);
    endtask

    // Called at a negedge; takes one result with res_ready held high.
    task automatic get_res(input string tag, input logic [7:0] exp_d, input logic exp_e);
        bit ok = 0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus.res_valid) begin
                $display("res  %s data=%02h err=%0d (exp %02h/%0d)", tag, bus.res_data, bus.res_err, exp_d, exp_e);
                check({tag, "_data"}, bus.res_data, exp_d);
                check({tag, "_err"}, bus.res_err, exp_e);
                @(posedge clk);
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int acc;
        logic [7:0] oc;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'h0;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.res_ready = 1'b0;

        // Reset and idle.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_res_valid", bus.res_valid, 0);
            check("idle_cmd_ready", bus.cmd_ready, 1);
            check("idle_busy", busy, 0);
            check("idle_opcode", alu_opcode, 0);
        end
        check("rst_num1", alu_num_1, 0);
        check("rst_num2", alu_num_2, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_err", bus.res_err, 0);
        check("rst_op_count", op_count, 0);

        // Single ADD latency.
        push_cmd(4'h1, 8'h0F, 8'h01);
        bus.cmd_valid = 1'b0;
        check("lat_e0_valid", bus.res_valid, 0);
        check("lat_e0_busy", busy, 1);
        @(negedge clk);
        check("lat_e1_opcode", alu_opcode, 4'h1);
        check("lat_e1_num1", alu_num_1, 8'h0F);
        check("lat_e1_num2", alu_num_2, 8'h01);
        check("lat_e1_valid", bus.res_valid, 0);
        @(negedge clk);
        check("lat_e2_valid", bus.res_valid, 0);
        @(negedge clk);
        check("lat_e3_valid", bus.res_valid, 1);
        check("lat_e3_data", bus.res_data, 8'h10);
        check("lat_e3_err", bus.res_err, 0);
        check("lat_e3_opcode", alu_opcode, 4'h0);
        check("lat_e3_num1", alu_num_1, 8'h0F);
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("lat_hs_valid", bus.res_valid, 0);
        check("lat_hs_count", op_count, 1);
        check("lat_hs_busy", busy, 0);
        $display("res  add data=10 op_count=%0d", op_count);

        // Back-to-back, in order.
        push_cmd(4'h2, 8'h00, 8'h01);
        push_cmd(4'h4, 8'hF3, 8'h25);
        push_cmd(4'h8, 8'd10, 8'h00);
        bus.cmd_valid = 1'b0;
        get_res("sub", 8'hFF, 0);
        get_res("mul", 8'h0F, 0);
        get_res("mod3", 8'h01, 0);
        check("b2b_count", op_count, 4);

        // Unsupported opcode then ADD.
        push_cmd(4'h3, 8'h12, 8'h34);
        push_cmd(4'h1, 8'h01, 8'h01);
        bus.cmd_valid = 1'b0;
        get_res("badop", 8'hFF, 1);
        get_res("add_after", 8'h02, 0);

        // Backpressure: 1 in flight plus 4 queued.
        bus.res_ready = 1'b0;
        acc = 0;
        bus.cmd_op = 4'h1;
        bus.cmd_b  = 8'h10;
        for (int i = 0; i < 10; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_a     = 8'(acc);
            if (bus.cmd_ready) begin
                $display("cmd  op=1 a=%02h b=10 accepted=1", acc);
                acc++;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        check("bp_accepted", acc, 5);
        check("bp_cmd_ready", bus.cmd_ready, 0);
        get_res("bp0", 8'h10, 0);
        check("bp_ready_back", bus.cmd_ready, 1);
        get_res("bp1", 8'h11, 0);
        get_res("bp2", 8'h12, 0);
        get_res("bp3", 8'h13, 0);
        get_res("bp4", 8'h14, 0);
        check("bp_count", op_count, 11);

        // Reset during WAIT with two commands queued.
        bus.res_ready = 1'b0;
        push_cmd(4'h1, 8'h05, 8'h05);
        push_cmd(4'h1, 8'h06, 8'h06);
        push_cmd(4'h1, 8'h07, 8'h07);
        bus.cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", bus.res_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_cmd_ready", bus.cmd_ready, 1);
        check("mrst_opcode", alu_opcode, 0);
        check("mrst_num1", alu_num_1, 0);
        check("mrst_count", op_count, 0);
        $display("rst  mid-operation applied");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_valid", bus.res_valid, 0);
            check("post_rst_busy", busy, 0);
        end
        push_cmd(4'h1, 8'h03, 8'h04);
        bus.cmd_valid = 1'b0;
        get_res("post_rst_add", 8'h07, 0);
        check("post_rst_count", op_count, 1);

        // op_count wrap after 256 handshakes.
        for (int i = 1; i < 256; i++) begin
            oc = 8'(i);
            push_cmd(4'h1, oc, oc);
            bus.cmd_valid = 1'b0;
            get_res("wrap_add", oc + oc, 0);
        end
        check("wrap_count", op_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
